apb_master_ctrl: RTL and testbench
==================================

Name: apb_master_ctrl

Overview:
APB-side transfer engine of the AHB-to-APB bridge. Takes one registered request from the AHB capture stage, including the write strobe and size-error flag produced by the strobe decoder. Runs the APB SETUP/ACCESS sequence with a wait-state timeout, then returns read data and error status to the AHB response logic through a valid/ready handshake.

Parameters:
ADDR_W, 32, width of req_addr and PADDR
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before forced error; 0 disables the timeout

Ports:
HCLK  in  1  bridge clock
HRESETn  in  1  asynchronous active-low reset
req_valid  in  1  request available from AHB capture stage
req_ready  out  1  engine accepts request this cycle
req_addr  in  ADDR_W  transfer address
req_write  in  1  1 = write, 0 = read
req_wdata  in  32  write data
req_strb  in  4  decoded byte strobe (p_strb)
req_size_err  in  1  unsupported HSIZE flag (size_err)
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PWDATA  out  32  APB write data
PSTRB  out  4  APB write strobe
PREADY  in  1  APB ready
PRDATA  in  32  APB read data
PSLVERR  in  1  APB slave error
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  32  read data (0 for writes and errors)
rsp_err  out  1  transfer error (size, slave, or timeout)

Behaviour:
- Reset state: IDLE. All outputs are 0 except req_ready, which is 1. The wait counter resets to 0.
- Reset is asynchronous. Asserting HRESETn low mid-transfer drops PSEL and PENABLE immediately. No response is produced for the aborted transfer.
- All APB and rsp outputs are registered. req_ready is 1 only in IDLE.
- IDLE: a request is accepted when req_valid is 1; req_ready is 1 in this state. On acceptance, addr, write, wdata, strb and size_err are latched.
  - If size_err = 0: go to SETUP.
  - If size_err = 1: go to RESP with rsp_err = 1. PSEL is never asserted.
- SETUP (one cycle): PSEL = 1, PENABLE = 0.
  - PADDR, PWRITE and PWDATA come from the latched values.
  - PSTRB = latched strb for writes, 4'b0000 for reads.
  - Always go to ACCESS.
- ACCESS: PSEL = 1, PENABLE = 1. PADDR, PWRITE, PWDATA and PSTRB are held stable.
  - PREADY = 1: capture rsp_err = PSLVERR. Capture rsp_rdata = PRDATA if the transfer is a read and PSLVERR = 0, else 0. Drop PSEL/PENABLE next cycle. Go to RESP.
  - PREADY = 0: increment the wait counter.
  - Timeout: if TIMEOUT_CYCLES > 0, the counter equals TIMEOUT_CYCLES-1, and PREADY = 0, go to RESP with rsp_err = 1 and rsp_rdata = 0. PSEL/PENABLE drop next cycle.
  - If PREADY = 1 arrives on the timeout cycle, it wins and the transfer completes normally.
- RESP: rsp_valid = 1; rsp_rdata and rsp_err are held.
  - Leave when rsp_ready = 1: go to IDLE, clear rsp_valid, clear the counter.
  - rsp_ready may already be high on the cycle rsp_valid rises.
- Latency: a zero-wait APB transfer takes 3 cycles from the acceptance edge to rsp_valid (SETUP, ACCESS, RESP).
  - A size-error transfer takes 1 cycle.
  - Minimum spacing between request acceptances is 4 cycles with rsp_ready tied high.
- PSLVERR is sampled only when PSEL, PENABLE and PREADY are all 1.
- The counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. The counter saturates and never wraps.
- req_* inputs are don't-care outside IDLE.

Decomposition:
- Shared package bridge_pkg holds:
  - typedef enum apb_state_t {IDLE, SETUP, ACCESS, RESP}
  - localparams APB_DATA_W = 32 and APB_STRB_W = 4
  - these are also used by p_strb_decoder and the AHB capture stage.
- One natural sub-module, apb_wait_timer: a counter with clear, enable and a timeout flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write: addr 0x40, wdata 0xDEADBEEF, strb 4'b0011, PREADY tied 1 -> one SETUP cycle, then one ACCESS cycle with PSTRB = 0011; rsp_valid 3 cycles after acceptance, rsp_err = 0, rsp_rdata = 0.
- Read: addr 0x44, PREADY low for 2 ACCESS cycles, then high with PRDATA = 0x12345678 -> PSTRB = 0000; PADDR stable across all 3 ACCESS cycles; rsp_rdata = 0x12345678.
- Size error: req_size_err = 1 -> PSEL never rises; rsp_valid next cycle with rsp_err = 1.
- Timeout: TIMEOUT_CYCLES = 4, PREADY held 0 -> exactly 4 ACCESS cycles; PSEL drops; rsp_err = 1, rsp_rdata = 0. A second run with PREADY = 1 on the 4th cycle -> normal completion.
- Slave error and backpressure: PSLVERR = 1 with PREADY = 1 on a read returning 0xFFFF0000 -> rsp_err = 1, rsp_rdata = 0; with rsp_ready held low 5 cycles -> rsp_valid/rsp_err held, req_ready stays 0.
- Reset mid-ACCESS: HRESETn low -> PSEL/PENABLE go 0 asynchronously, req_ready = 1 and rsp_valid = 0 after release; the next request completes normally.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge.
// Holds the APB engine state type, APB bus widths and a strobe helper.
// The strobe decoder and the AHB capture stage also import this package.
package bridge_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

  // APB reads must present an all-zero strobe.
  function automatic logic [APB_STRB_W-1:0] apb_strb(input logic                  write,
                                                     input logic [APB_STRB_W-1:0] strb);
    return write ? strb : '0;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : clear the count (has priority over en_i)
//   en_i          : count one wait cycle
//   timeout_o     : count has reached TIMEOUT_CYCLES-1 (never set when TIMEOUT_CYCLES == 0)
// The count saturates at its all-ones value instead of wrapping.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] TermCnt =
      CntW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (TIMEOUT_CYCLES > 0) && (cnt_q == TermCnt);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB-side transfer engine of the AHB-to-APB bridge.
// Accepts one request (address, direction, data, strobe, size-error flag) from the AHB
// capture stage, runs the APB SETUP/ACCESS sequence with a wait-state timeout and hands
// read data plus error status back through a valid/ready response handshake.
// Ports:
//   HCLK, HRESETn                 : clock, asynchronous active-low reset
//   req_*                         : request handshake and payload (sampled only in IDLE)
//   PSEL..PSTRB, PREADY..PSLVERR  : APB master interface (outputs registered)
//   rsp_valid/ready/rdata/err     : response handshake (outputs registered)
module apb_master_ctrl
  import bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_write,
  input  logic [APB_DATA_W-1:0] req_wdata,
  input  logic [APB_STRB_W-1:0] req_strb,
  input  logic                  req_size_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic                  PWRITE,
  output logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_STRB_W-1:0] PSTRB,
  input  logic                  PREADY,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PSLVERR,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err
);

  apb_state_t            state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic [APB_STRB_W-1:0] pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic timer_clr, timer_en, timer_timeout;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i    (HCLK),
    .rst_ni   (HRESETn),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .timeout_o(timer_timeout)
  );

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          timer_clr = 1'b1;
          if (req_size_err) begin
            // Unsupported size never reaches the APB bus.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            paddr_d  = req_addr;
            pwrite_d = req_write;
            pwdata_d = req_wdata;
            pstrb_d  = apb_strb(req_write, req_strb);
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        // PSEL/PENABLE are both high here, so PREADY alone qualifies PSLVERR.
        // A PREADY on the timeout cycle takes priority over the timeout.
        if (PREADY) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
        end else begin
          timer_en = 1'b1;
          if (timer_timeout) begin
            state_d     = RESP;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          timer_clr   = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed self-checking bench for apb_master_ctrl (TIMEOUT_CYCLES = 4).
// Each transfer is described at transaction level; the sequencer derives the expected
// APB/response timeline from it and a negedge process compares every cycle.
module tb_apb_master_ctrl;

  localparam int TO = 4;

  logic        HCLK, HRESETn;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        req_size_err;
  logic        PSEL, PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  apb_master_ctrl #(
    .ADDR_W        (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .req_size_err(req_size_err),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PADDR       (PADDR),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PREADY      (PREADY),
    .PRDATA      (PRDATA),
    .PSLVERR     (PSLVERR),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Expected per-cycle outputs, maintained by the sequencer.
  logic        chk_en = 1'b0;
  logic        exp_req_ready, exp_psel, exp_penable, exp_pwrite, exp_rsp_valid, exp_rsp_err;
  logic [31:0] exp_paddr, exp_pwdata, exp_rsp_rdata;
  logic [3:0]  exp_pstrb;

  // Observations used by the literal pins.
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rsp_rise_cyc = 0;
  int          access_cnt = 0;
  logic        rsp_seen = 1'b0;
  logic [3:0]  last_pstrb = '0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  initial begin
    forever begin
      @(negedge HCLK);
      cyc++;
      if (chk_en) begin
        check("req_ready", {31'b0, req_ready}, {31'b0, exp_req_ready});
        check("psel", {31'b0, PSEL}, {31'b0, exp_psel});
        check("penable", {31'b0, PENABLE}, {31'b0, exp_penable});
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rsp_valid});
        if (exp_psel) begin
          check("paddr", PADDR, exp_paddr);
          check("pwrite", {31'b0, PWRITE}, {31'b0, exp_pwrite});
          check("pwdata", PWDATA, exp_pwdata);
          check("pstrb", {28'b0, PSTRB}, {28'b0, exp_pstrb});
        end
        if (exp_rsp_valid) begin
          check("rsp_rdata", rsp_rdata, exp_rsp_rdata);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_rsp_err});
        end
      end
      if (req_valid && req_ready) acc_cyc = cyc;
      if (rsp_valid && !rsp_seen) rsp_rise_cyc = cyc;
      rsp_seen = rsp_valid;
      if (PSEL && PENABLE) begin
        access_cnt++;
        last_pstrb = PSTRB;
      end
      if (rsp_valid) begin
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
      end
    end
  end

  task automatic cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_req_ready = 1'b1;
    exp_psel      = 1'b0;
    exp_penable   = 1'b0;
    exp_rsp_valid = 1'b0;
  endtask

  // One complete transfer. waits = ACCESS cycles with PREADY low before PREADY rises;
  // waits >= TO means PREADY never rises. delay = cycles rsp_ready stays low.
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic size_err, input int waits,
                          input logic slverr, input logic [31:0] prdata, input int delay);
    logic timed_out;
    int   n_acc;
    timed_out  = !size_err && (waits >= TO);
    n_acc      = size_err ? 0 : (timed_out ? TO : waits + 1);
    access_cnt = 0;

    req_valid    = 1'b1;
    req_addr     = addr;
    req_write    = wr;
    req_wdata    = wdata;
    req_strb     = strb;
    req_size_err = size_err;
    set_idle_exp();
    cycle();
    req_valid    = 1'b0;
    req_addr     = 32'h5A5A_0000;
    req_size_err = 1'b0;
    exp_req_ready = 1'b0;

    if (!size_err) begin
      exp_psel    = 1'b1;
      exp_penable = 1'b0;
      exp_paddr   = addr;
      exp_pwrite  = wr;
      exp_pwdata  = wdata;
      exp_pstrb   = wr ? strb : 4'b0000;
      cycle();
      exp_penable = 1'b1;
      for (int i = 0; i < n_acc; i++) begin
        PREADY  = (i == waits);
        // PSLVERR noise while PREADY is low must be ignored.
        PSLVERR = (i == waits) ? slverr : 1'b1;
        PRDATA  = (i == waits) ? prdata : 32'hBAD0_BAD0;
        cycle();
      end
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
    end

    exp_psel      = 1'b0;
    exp_penable   = 1'b0;
    exp_rsp_valid = 1'b1;
    exp_rsp_err   = size_err ? 1'b1 : (timed_out ? 1'b1 : slverr);
    exp_rsp_rdata = (!size_err && !timed_out && !wr && !slverr) ? prdata : 32'h0;
    for (int d = 0; d <= delay; d++) begin
      rsp_ready = (d == delay);
      cycle();
    end
    rsp_ready = 1'b0;
    set_idle_exp();
  endtask

  initial begin
    HRESETn      = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_write    = 1'b0;
    req_wdata    = '0;
    req_strb     = '0;
    req_size_err = 1'b0;
    PREADY       = 1'b0;
    PRDATA       = '0;
    PSLVERR      = 1'b0;
    rsp_ready    = 1'b0;
    set_idle_exp();
    repeat (2) @(posedge HCLK);
    #1;

    // Reset state.
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_psel", {31'b0, PSEL}, 32'd0);
    check("rst_penable", {31'b0, PENABLE}, 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    check("rst_pwrite", {31'b0, PWRITE}, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_pstrb", {28'b0, PSTRB}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);

    HRESETn = 1'b1;
    chk_en  = 1'b1;
    cycle();

    // Zero-wait write.
    run_xfer(32'h40, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b0, 0, 1'b0, 32'h0, 0);
    check("wr_latency", rsp_rise_cyc - acc_cyc, 32'd3);
    check("wr_access_cycles", access_cnt, 32'd1);
    check("wr_pstrb", {28'b0, last_pstrb}, 32'h3);
    check("wr_err", {31'b0, last_err}, 32'd0);
    check("wr_rdata", last_rdata, 32'd0);

    // Read with two wait states, issued back to back.
    run_xfer(32'h44, 1'b0, 32'h1111_2222, 4'b1111, 1'b0, 2, 1'b0, 32'h1234_5678, 0);
    check("rd_latency", rsp_rise_cyc - acc_cyc, 32'd5);
    check("rd_access_cycles", access_cnt, 32'd3);
    check("rd_pstrb", {28'b0, last_pstrb}, 32'h0);
    check("rd_rdata", last_rdata, 32'h1234_5678);

    // Size error: no APB activity, response one cycle after acceptance.
    run_xfer(32'h48, 1'b1, 32'h0, 4'b1111, 1'b1, 0, 1'b0, 32'h0, 0);
    check("szerr_latency", rsp_rise_cyc - acc_cyc, 32'd1);
    check("szerr_access_cycles", access_cnt, 32'd0);
    check("szerr_err", {31'b0, last_err}, 32'd1);

    // Timeout: PREADY never rises.
    run_xfer(32'h4C, 1'b0, 32'h0, 4'b0000, 1'b0, 100, 1'b0, 32'hAAAA_5555, 0);
    check("to_access_cycles", access_cnt, 32'd4);
    check("to_err", {31'b0, last_err}, 32'd1);
    check("to_rdata", last_rdata, 32'd0);

    // PREADY on the timeout cycle wins.
    run_xfer(32'h50, 1'b0, 32'h0, 4'b0000, 1'b0, 3, 1'b0, 32'hCAFE_F00D, 0);
    check("to_edge_access_cycles", access_cnt, 32'd4);
    check("to_edge_err", {31'b0, last_err}, 32'd0);
    check("to_edge_rdata", last_rdata, 32'hCAFE_F00D);

    // Slave error on a read with 5 cycles of response backpressure.
    run_xfer(32'h54, 1'b0, 32'h0, 4'b0000, 1'b0, 0, 1'b1, 32'hFFFF_0000, 5);
    check("slverr_err", {31'b0, last_err}, 32'd1);
    check("slverr_rdata", last_rdata, 32'd0);

    // Reset while in ACCESS.
    chk_en       = 1'b0;
    req_valid    = 1'b1;
    req_addr     = 32'h80;
    req_write    = 1'b0;
    req_size_err = 1'b0;
    PREADY       = 1'b0;
    cycle();
    req_valid = 1'b0;
    cycle();
    check("prerst_penable", {31'b0, PENABLE}, 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    check("arst_psel", {31'b0, PSEL}, 32'd0);
    check("arst_penable", {31'b0, PENABLE}, 32'd0);
    check("arst_req_ready", {31'b0, req_ready}, 32'd1);
    cycle();
    HRESETn = 1'b1;
    cycle();
    check("postrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("postrst_req_ready", {31'b0, req_ready}, 32'd1);
    set_idle_exp();
    chk_en = 1'b1;

    // Normal write after reset.
    run_xfer(32'h84, 1'b1, 32'h0BAD_F00D, 4'b1100, 1'b0, 1, 1'b0, 32'h0, 1);
    check("postrst_latency", rsp_rise_cyc - acc_cyc, 32'd4);
    check("postrst_pstrb", {28'b0, last_pstrb}, 32'hC);
    check("postrst_err", {31'b0, last_err}, 32'd0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
